// File: rtl/rs_stream_decoder_t1.sv
// Streaming single-symbol-error RS(N,N-2) decoder: Horner syndromes on input, ping-pong
// buffering, and a divider-free Chien-style replay that corrects at most one symbol.
module rs_stream_decoder_t1 #(
  parameter int              SYM_W     = 8,
  parameter int              N         = 18,
  parameter logic [SYM_W:0]  PRIM_POLY = (SYM_W+1)'('h11D)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SYM_W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SYM_W-1:0] out_data,
  output logic             out_last,
  output logic [1:0]       out_status
);

  // Handshake: a beat moves on a port exactly in a cycle where valid && ready are both high
  // at the rising edge; the producer holds data stable while valid is high and ready is low.

  function automatic logic [SYM_W-1:0] mul_a(input logic [SYM_W-1:0] x);
    logic [SYM_W:0] t;
    t = {x, 1'b0};
    if (t[SYM_W]) t = t ^ PRIM_POLY;
    return t[SYM_W-1:0];
  endfunction

  function automatic logic [SYM_W-1:0] apow(input int p);
    logic [SYM_W-1:0] r;
    r = SYM_W'(1);
    for (int i = 0; i < p; i++) r = mul_a(r);
    return r;
  endfunction

  // Used only with a constant second operand, so it reduces to a fixed XOR network.
  function automatic logic [SYM_W-1:0] gf_mul(input logic [SYM_W-1:0] x,
                                              input logic [SYM_W-1:0] c);
    logic [SYM_W-1:0] r;
    r = '0;
    for (int i = SYM_W-1; i >= 0; i--) r = mul_a(r) ^ (c[i] ? x : '0);
    return r;
  endfunction

  localparam int Q  = (1 << SYM_W) - 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [SYM_W-1:0] A1        = apow(1);
  localparam logic [SYM_W-1:0] A2        = apow(2);
  localparam logic [SYM_W-1:0] AINV      = apow(Q - 1);
  localparam logic [SYM_W-1:0] A_NM1     = apow(N - 1);
  localparam logic [SYM_W-1:0] A_NEG_NM1 = apow(Q - (N - 1));
  localparam logic [CW-1:0]    J_TOP     = CW'(N - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [SYM_W-1:0] mem_q [2][N];
  logic [SYM_W-1:0] syn1_q [2];
  logic [SYM_W-1:0] syn2_q [2];

  logic             wb_q, wb_d;
  logic             rb_q, rb_d;
  logic [CW-1:0]    wc_q, wc_d;
  logic [CW-1:0]    j_q, j_d;
  logic [SYM_W-1:0] acc1_q, acc1_d;
  logic [SYM_W-1:0] acc2_q, acc2_d;
  logic [1:0]       full_q, full_d;
  logic [0:0]       state_q, state_d;
  logic [SYM_W-1:0] l_q, l_d;
  logic [SYM_W-1:0] e_q, e_d;
  logic             found_q, found_d;

  logic             in_fire, wr_done, out_fire, run, hit;
  logic [SYM_W-1:0] s1_fin, s2_fin, rd_s1, rd_s2, lb_s1;
  logic             lb, lb_fresh, lb_avail, load_slot;

  assign in_ready  = !reset && !full_q[wb_q];
  assign in_fire   = in_valid && in_ready;
  assign wr_done   = in_fire && (wc_q == '0);
  assign s1_fin    = gf_mul(acc1_q, A1) ^ in_data;
  assign s2_fin    = gf_mul(acc2_q, A2) ^ in_data;

  assign run       = (state_q == ST_RUN);
  assign out_valid = run && !reset;
  assign out_fire  = out_valid && out_ready;
  assign rd_s1     = syn1_q[rb_q];
  assign rd_s2     = syn2_q[rb_q];
  assign hit       = (l_q == rd_s2) && (rd_s1 != '0) && (rd_s2 != '0) && !found_q;

  // The bank to replay next may be completing in this very cycle; take its syndrome
  // straight from the accumulator so the replay starts one cycle after the last symbol.
  assign lb        = run ? ~rb_q : rb_q;
  assign lb_fresh  = wr_done && (wb_q == lb);
  assign lb_avail  = full_q[lb] || lb_fresh;
  assign lb_s1     = lb_fresh ? s1_fin : syn1_q[lb];
  assign load_slot = !run || (out_fire && (j_q == '0));

  always_comb begin
    wb_d    = wb_q;
    wc_d    = wc_q;
    acc1_d  = acc1_q;
    acc2_d  = acc2_q;
    full_d  = full_q;
    rb_d    = rb_q;
    state_d = state_q;
    j_d     = j_q;
    l_d     = l_q;
    e_d     = e_q;
    found_d = found_q;

    if (in_fire) begin
      if (wr_done) begin
        full_d[wb_q] = 1'b1;
        wb_d         = ~wb_q;
        wc_d         = J_TOP;
        acc1_d       = '0;
        acc2_d       = '0;
      end else begin
        wc_d   = wc_q - CW'(1);
        acc1_d = s1_fin;
        acc2_d = s2_fin;
      end
    end

    if (out_fire) begin
      if (j_q == '0) begin
        full_d[rb_q] = 1'b0;
        rb_d         = ~rb_q;
        state_d      = ST_IDLE;
      end else begin
        l_d     = gf_mul(l_q, AINV);
        e_d     = gf_mul(e_q, A1);
        j_d     = j_q - CW'(1);
        found_d = found_q | hit;
      end
    end

    if (load_slot && lb_avail) begin
      state_d = ST_RUN;
      rb_d    = lb;
      j_d     = J_TOP;
      l_d     = gf_mul(lb_s1, A_NM1);
      e_d     = gf_mul(lb_s1, A_NEG_NM1);
      found_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_q      <= 1'b0;
      rb_q      <= 1'b0;
      wc_q      <= J_TOP;
      j_q       <= J_TOP;
      acc1_q    <= '0;
      acc2_q    <= '0;
      full_q    <= '0;
      state_q   <= ST_IDLE;
      l_q       <= '0;
      e_q       <= '0;
      found_q   <= 1'b0;
      syn1_q[0] <= '0;
      syn1_q[1] <= '0;
      syn2_q[0] <= '0;
      syn2_q[1] <= '0;
    end else begin
      wb_q    <= wb_d;
      rb_q    <= rb_d;
      wc_q    <= wc_d;
      j_q     <= j_d;
      acc1_q  <= acc1_d;
      acc2_q  <= acc2_d;
      full_q  <= full_d;
      state_q <= state_d;
      l_q     <= l_d;
      e_q     <= e_d;
      found_q <= found_d;
      if (wr_done) begin
        syn1_q[wb_q] <= s1_fin;
        syn2_q[wb_q] <= s2_fin;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_fire) mem_q[wb_q][wc_q] <= in_data;
  end

  assign out_data = out_valid ? (mem_q[rb_q][j_q] ^ (hit ? e_q : '0)) : '0;
  assign out_last = out_valid && (j_q == '0);

  always_comb begin
    out_status = 2'b00;
    if (out_last) begin
      if ((rd_s1 == '0) && (rd_s2 == '0)) out_status = 2'b00;
      else if (found_q || hit)            out_status = 2'b01;
      else                                out_status = 2'b10;
    end
  end

endmodule

// File: tb/tb_rs_stream_decoder_t1.sv
// Bench for rs_stream_decoder_t1: log/antilog reference decoder feeds an expected-beat
// queue; a negedge monitor compares every presented output beat against the queue head.
module tb_rs_stream_decoder_t1;

  localparam int SYM_W = 8;
  localparam int N     = 18;
  localparam int Q     = 255;
  localparam int W     = SYM_W + 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [SYM_W-1:0] in_data;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [SYM_W-1:0] out_data;
  logic             out_last;
  logic [1:0]       out_status;

  rs_stream_decoder_t1 #(
    .SYM_W     (SYM_W),
    .N         (N),
    .PRIM_POLY (9'h11D)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .out_status (out_status)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [SYM_W-1:0] gf_exp [0:Q-1];
  int               gf_log [0:Q];
  logic [SYM_W-1:0] cw_a [N];
  logic [W-1:0]     exp_q [$];
  int               n_vec = 0;
  int               n_err = 0;
  int               rdy_mode = 0;

  task automatic init_tables();
    logic [SYM_W:0] t;
    logic [SYM_W-1:0] x;
    x = 8'd1;
    for (int i = 0; i < Q; i++) begin
      gf_exp[i] = x;
      gf_log[x] = i;
      t = {x, 1'b0};
      if (t[SYM_W]) t = t ^ 9'h11D;
      x = t[SYM_W-1:0];
    end
    gf_log[0] = 0;
  endtask

  function automatic logic [SYM_W-1:0] gmul(input logic [SYM_W-1:0] a, input logic [SYM_W-1:0] b);
    if (a == 0 || b == 0) return 8'd0;
    return gf_exp[(gf_log[a] + gf_log[b]) % Q];
  endfunction

  function automatic logic [SYM_W-1:0] gdiv(input logic [SYM_W-1:0] a, input logic [SYM_W-1:0] b);
    if (a == 0) return 8'd0;
    return gf_exp[(gf_log[a] - gf_log[b] + Q) % Q];
  endfunction

  function automatic logic [SYM_W-1:0] apw(input int p);
    return gf_exp[p % Q];
  endfunction

  // Random data in r_2..r_{N-1}; r_1, r_0 solved so that S1 = S2 = 0.
  task automatic make_codeword();
    logic [SYM_W-1:0] p1, p2, r1;
    p1 = 0;
    p2 = 0;
    for (int j = 2; j < N; j++) begin
      cw_a[j] = 8'($urandom_range(0, 255));
      p1 ^= gmul(cw_a[j], apw(j));
      p2 ^= gmul(cw_a[j], apw(2 * j));
    end
    r1 = gdiv(p1 ^ p2, apw(1) ^ apw(2));
    cw_a[1] = r1;
    cw_a[0] = p1 ^ gmul(r1, apw(1));
  endtask

  task automatic inject(input int nerr);
    for (int k = 0; k < nerr; k++)
      cw_a[$urandom_range(0, N-1)] ^= 8'($urandom_range(1, 255));
  endtask

  task automatic push_expected();
    logic [SYM_W-1:0] s1, s2;
    logic [SYM_W-1:0] c [N];
    logic [1:0] st;
    int p;
    s1 = 0;
    s2 = 0;
    c  = cw_a;
    for (int j = 0; j < N; j++) begin
      s1 ^= gmul(cw_a[j], apw(j));
      s2 ^= gmul(cw_a[j], apw(2 * j));
    end
    if (s1 == 0 && s2 == 0) st = 2'b00;
    else if (s1 != 0 && s2 != 0) begin
      p = (gf_log[s2] - gf_log[s1] + Q) % Q;
      if (p < N) begin
        c[p] ^= gdiv(s1, apw(p));
        st = 2'b01;
      end else st = 2'b10;
    end else st = 2'b10;
    for (int j = N-1; j >= 0; j--) exp_q.push_back({(j == 0), st, c[j]});
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  logic [W-1:0] mon_e;
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_beat: got data %0h, required no output (t=%0t)", out_data, $time);
      end else begin
        mon_e = exp_q[0];
        check("out_data", 32'(out_data), 32'(mon_e[SYM_W-1:0]));
        check("out_last", 32'(out_last), 32'(mon_e[SYM_W+2]));
        if (mon_e[SYM_W+2]) check("out_status", 32'(out_status), 32'(mon_e[SYM_W+1:SYM_W]));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  always @(posedge clk) begin
    #1;
    out_ready = (rdy_mode == 1) ? ($urandom_range(0, 1) == 1) : 1'b1;
  end

  // ---------------- driver tasks ----------------
  task automatic send_cw(input int gap_max, input bit chk_ready, input int stop_after);
    int t;
    int sent;
    sent = 0;
    for (int j = N-1; j >= 0; j--) begin
      if (stop_after >= 0 && sent == stop_after) break;
      if (gap_max > 0) repeat ($urandom_range(0, gap_max)) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = cw_a[j];
      t = 0;
      @(negedge clk);
      if (chk_ready) check("in_ready_b2b", 32'(in_ready), 32'd1);
      while (!in_ready && t < 300) begin
        @(negedge clk);
        t++;
      end
      if (!in_ready) begin
        n_vec++;
        n_err++;
        $display("FAIL in_ready_timeout: got in_ready 0 for %0d cycles, required 1", t);
        in_valid = 1'b0;
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
      sent++;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 5000) begin
      @(posedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: got %0d beats outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic load_zero();
    for (int j = 0; j < N; j++) cw_a[j] = 8'd0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    init_tables();
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("in_ready_in_reset", 32'(in_ready), 32'd0);
    check("out_valid_in_reset", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_out_status", 32'(out_status), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    @(posedge clk); #1;

    // Directed: clean zeros, single error at j=0 and j=N-1, syndrome-split pattern.
    load_zero();
    push_expected();
    send_cw(0, 1'b0, -1);
    @(negedge clk);
    if (!out_valid) @(negedge clk);
    check("first_out_latency", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    load_zero(); cw_a[0] = 8'h55;
    push_expected(); send_cw(0, 1'b0, -1);
    load_zero(); cw_a[N-1] = 8'h01;
    push_expected(); send_cw(0, 1'b0, -1);
    load_zero(); cw_a[0] = 8'h02; cw_a[1] = 8'h01;
    push_expected(); send_cw(0, 1'b0, -1);
    wait_drain();

    // Back-to-back: no input gaps, sink always ready.
    for (int k = 0; k < 4; k++) begin
      make_codeword();
      inject($urandom_range(0, 1));
      push_expected();
      send_cw(0, 1'b1, -1);
    end
    wait_drain();

    // Random traffic with a stalling sink and 0..2 symbol errors.
    rdy_mode = 1;
    for (int k = 0; k < 30; k++) begin
      make_codeword();
      inject($urandom_range(0, 2));
      push_expected();
      send_cw(3, 1'b0, -1);
    end
    wait_drain();

    // Reset with one codeword buffered/draining and another partially written.
    make_codeword();
    inject(1);
    push_expected();
    send_cw(1, 1'b0, -1);
    make_codeword();
    send_cw(0, 1'b0, 7);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_out_valid", 32'(out_valid), 32'd0);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    make_codeword();
    inject(1);
    push_expected();
    send_cw(2, 1'b0, -1);
    wait_drain();

    repeat (5) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
